// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and request decode for the EX-stage mul/div sequencer.
package muldiv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned OP_W     = 6;

  localparam int unsigned OP_DIV   = 0;
  localparam int unsigned OP_DIVU  = 1;
  localparam int unsigned OP_MULT  = 2;
  localparam int unsigned OP_MULTU = 3;
  localparam int unsigned OP_MTHI  = 4;
  localparam int unsigned OP_MTLO  = 5;

  localparam int unsigned QUO_MSB  = 63;
  localparam int unsigned QUO_LSB  = 32;
  localparam int unsigned REM_MSB  = 31;
  localparam int unsigned REM_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OPK_NONE  = 3'd0,
    OPK_DIV   = 3'd1,
    OPK_DIVU  = 3'd2,
    OPK_MULT  = 3'd3,
    OPK_MULTU = 3'd4,
    OPK_MTHI  = 3'd5,
    OPK_MTLO  = 3'd6
  } op_kind_e;

  // Resolve a (nominally one-hot) op vector; lowest bit index wins.
  function automatic op_kind_e decode_op(input logic [OP_W-1:0] op);
    op_kind_e k;
    k = OPK_NONE;
    if      (op[OP_DIV])   k = OPK_DIV;
    else if (op[OP_DIVU])  k = OPK_DIVU;
    else if (op[OP_MULT])  k = OPK_MULT;
    else if (op[OP_MULTU]) k = OPK_MULTU;
    else if (op[OP_MTHI])  k = OPK_MTHI;
    else if (op[OP_MTLO])  k = OPK_MTLO;
    return k;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Operand/result port shared by the signed and unsigned divider IPs.
interface muldiv_if;
  import muldiv_pkg::*;

  logic                div_tvalid;
  logic                div_tready;
  logic                div_signed;
  logic [XLEN-1:0]     div_dividend;
  logic [XLEN-1:0]     div_divisor;
  logic                div_dout_tvalid;
  logic [2*XLEN-1:0]   div_dout_tdata;

  modport master (
    output div_tvalid, div_signed, div_dividend, div_divisor,
    input  div_tready, div_dout_tvalid, div_dout_tdata
  );

  modport slave (
    input  div_tvalid, div_signed, div_dividend, div_divisor,
    output div_tready, div_dout_tvalid, div_dout_tdata
  );
endinterface

// File: rtl/muldiv_div_fsm.sv
// Divider handshake sequencer (ISSUE/WAIT/DRAIN) with latency watchdog.
module muldiv_div_fsm
  import muldiv_pkg::*;
#(
  parameter int unsigned DIV_LAT_MAX = 40
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  logic            i_signed,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  input  logic            i_cancel,
  input  logic            i_req_valid,
  output state_e          o_state,
  output logic            o_stall_c,
  output logic            o_done_c,
  output logic            o_err_timeout,
  muldiv_if.master        dbus
);

  localparam int unsigned WD_W = $clog2(DIV_LAT_MAX + 1);

  state_e            r_state;
  logic [WD_W-1:0]   r_wd;
  logic              r_err;
  logic              r_signed;
  logic [XLEN-1:0]   r_dividend;
  logic [XLEN-1:0]   r_divisor;
  logic              w_dout;
  logic              w_wd_hit;

  assign w_dout   = dbus.div_dout_tvalid;
  assign w_wd_hit = (r_wd == WD_W'(DIV_LAT_MAX - 1));

  // A handshake that coincides with cancel still owes us a result, so drain it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_wd       <= '0;
      r_err      <= 1'b0;
      r_signed   <= 1'b0;
      r_dividend <= '0;
      r_divisor  <= '0;
    end else begin
      r_wd <= '0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state    <= ST_ISSUE;
            r_signed   <= i_signed;
            r_dividend <= i_dividend;
            r_divisor  <= i_divisor;
          end
        end
        ST_ISSUE: begin
          if (dbus.div_tready) r_state <= i_cancel ? ST_DRAIN : ST_WAIT;
          else if (i_cancel)   r_state <= ST_IDLE;
        end
        ST_WAIT: begin
          if (w_dout) begin
            r_state <= ST_IDLE;
          end else if (w_wd_hit) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b1;
          end else begin
            r_state <= i_cancel ? ST_DRAIN : ST_WAIT;
            r_wd    <= r_wd + WD_W'(1);
          end
        end
        ST_DRAIN: begin
          if (w_dout) begin
            r_state <= ST_IDLE;
          end else if (w_wd_hit) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b1;
          end else begin
            r_wd    <= r_wd + WD_W'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    o_stall_c = 1'b0;
    o_done_c  = 1'b0;
    case (r_state)
      ST_ISSUE: o_stall_c = 1'b1;
      ST_WAIT: begin
        o_done_c  = w_dout & ~i_cancel;
        o_stall_c = w_dout ? i_cancel : ~w_wd_hit;
      end
      ST_DRAIN: o_stall_c = i_req_valid;
      default: ;
    endcase
  end

  assign o_state           = r_state;
  assign o_err_timeout     = r_err;
  assign dbus.div_tvalid   = (r_state == ST_ISSUE);
  assign dbus.div_signed   = r_signed;
  assign dbus.div_dividend = r_dividend;
  assign dbus.div_divisor  = r_divisor;

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage mul/div sequencer and HI/LO owner.
// Optional build macro MULDIV_DIV0_SKIP_EN: zero-divisor divides complete in IDLE without the divider.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned DIV_LAT_MAX = 40
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic [OP_W-1:0] req_op,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  input  logic            cancel,
  output logic            stall,
  output logic            req_done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  muldiv_if.master        dbus,
  output logic            err_timeout
);

  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  op_kind_e          w_kind;
  state_e            w_state;
  logic              w_idle;
  logic              w_accept;
  logic              w_is_div;
  logic              w_div0;
  logic              w_start;
  logic              w_local_done;
  logic              w_fsm_stall;
  logic              w_fsm_done;
  logic [2*XLEN-1:0] w_prod_s;
  logic [2*XLEN-1:0] w_prod_u;

  assign w_kind   = decode_op(req_op);
  assign w_idle   = (w_state == ST_IDLE);
  assign w_accept = w_idle & req_valid & ~cancel & ~reset;
  assign w_is_div = (w_kind == OPK_DIV) | (w_kind == OPK_DIVU);

`ifdef MULDIV_DIV0_SKIP_EN
  assign w_div0 = w_is_div & (req_src2 == '0);
`else
  assign w_div0 = 1'b0;
`endif

  assign w_start      = w_accept & w_is_div & ~w_div0;
  assign w_local_done = w_accept & ((w_kind == OPK_MULT) | (w_kind == OPK_MULTU) |
                                    (w_kind == OPK_MTHI) | (w_kind == OPK_MTLO) | w_div0);

  // Lower 64 bits of the extended product equal the two's complement result.
  assign w_prod_s = {{XLEN{req_src1[XLEN-1]}}, req_src1} * {{XLEN{req_src2[XLEN-1]}}, req_src2};
  assign w_prod_u = {{XLEN{1'b0}}, req_src1} * {{XLEN{1'b0}}, req_src2};

  muldiv_div_fsm #(
    .DIV_LAT_MAX (DIV_LAT_MAX)
  ) u_div_fsm (
    .clk           (clk),
    .reset         (reset),
    .i_start       (w_start),
    .i_signed      (w_kind == OPK_DIV),
    .i_dividend    (req_src1),
    .i_divisor     (req_src2),
    .i_cancel      (cancel),
    .i_req_valid   (req_valid),
    .o_state       (w_state),
    .o_stall_c     (w_fsm_stall),
    .o_done_c      (w_fsm_done),
    .o_err_timeout (err_timeout),
    .dbus          (dbus)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_accept) begin
      case (w_kind)
        OPK_MULT:  {r_hi, r_lo} <= w_prod_s;
        OPK_MULTU: {r_hi, r_lo} <= w_prod_u;
        OPK_MTHI:  r_hi <= req_src1;
        OPK_MTLO:  r_lo <= req_src1;
        default: ;
      endcase
    end else if (w_fsm_done) begin
      r_lo <= dbus.div_dout_tdata[QUO_MSB:QUO_LSB];
      r_hi <= dbus.div_dout_tdata[REM_MSB:REM_LSB];
    end
  end

  assign stall    = ~reset & (w_idle ? w_start : w_fsm_stall);
  assign req_done = ~reset & (w_local_done | w_fsm_done);
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl with a behavioural divider on the slave side.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int unsigned LAT = 8;
  localparam logic [5:0] K_DIV   = 6'b000001;
  localparam logic [5:0] K_DIVU  = 6'b000010;
  localparam logic [5:0] K_MULT  = 6'b000100;
  localparam logic [5:0] K_MULTU = 6'b001000;
  localparam logic [5:0] K_MTHI  = 6'b010000;
  localparam logic [5:0] K_MTLO  = 6'b100000;

  logic        clk = 1'b0;
  logic        reset, req_valid, cancel;
  logic [5:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic        stall, req_done, err_timeout;
  logic [31:0] hi, lo;

  muldiv_if dif ();

  muldiv_ctrl #(.DIV_LAT_MAX(LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .req_src1    (req_src1),
    .req_src2    (req_src2),
    .cancel      (cancel),
    .stall       (stall),
    .req_done    (req_done),
    .hi          (hi),
    .lo          (lo),
    .dbus        (dif),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  // divider model knobs and observations
  int          m_tready_dly = 0;
  int          m_dout_dly   = 4;
  bit          m_dout_en    = 1'b1;
  int          tv_cnt = 0, pend = 0, hs_wait = -1;
  bit          unstable = 1'b0;
  logic [63:0] m_res;
  logic [31:0] hs_a, hs_b, prev_a, prev_b;
  logic        hs_s, prev_s;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] div_ref(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (sgn) begin
      sa = a; sb = b;
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
  endtask

  task automatic release_req();
    req_valid = 1'b0; req_op = '0;
  endtask

  task automatic push(input logic [31:0] eh, input logic [31:0] el, input string tag);
    exp_t e;
    e.hi = eh; e.lo = el; e.tag = tag;
    sb_q.push_back(e);
    m_hi = eh; m_lo = el;
  endtask

  // Counts stall-high cycles until stall drops; returns at the negedge of the release cycle.
  task automatic wait_release(input int max, output int n);
    n = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!stall) return;
      n++;
    end
    check_eq("wait_bound", stall, 0);
  endtask

  initial begin : divider_model
    dif.div_tready = 1'b0; dif.div_dout_tvalid = 1'b0; dif.div_dout_tdata = '0;
    forever begin
      @(negedge clk);
      if (dif.div_tvalid) begin
        if (tv_cnt > 0 && (dif.div_dividend !== prev_a || dif.div_divisor !== prev_b ||
                           dif.div_signed !== prev_s)) unstable = 1'b1;
        prev_a = dif.div_dividend; prev_b = dif.div_divisor; prev_s = dif.div_signed;
        if (dif.div_tready) begin
          hs_wait = tv_cnt;
          hs_a = dif.div_dividend; hs_b = dif.div_divisor; hs_s = dif.div_signed;
          m_res = div_ref(dif.div_signed, dif.div_dividend, dif.div_divisor);
          pend = m_dout_dly;
          tv_cnt = 0;
        end else begin
          tv_cnt++;
        end
      end else begin
        tv_cnt = 0;
      end
      @(posedge clk); #1;
      dif.div_tready      = dif.div_tvalid && (tv_cnt >= m_tready_dly);
      dif.div_dout_tvalid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0 && m_dout_en) begin
          dif.div_dout_tvalid = 1'b1;
          dif.div_dout_tdata  = m_res;
        end
      end
    end
  end

  initial begin : monitor
    bit   done_d;
    exp_t e;
    done_d = 1'b0;
    forever begin
      @(negedge clk);
      if (done_d) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_done", done_d, 0);
        end else begin
          e = sb_q.pop_front();
          check_eq({e.tag, "_hi"}, hi, e.hi);
          check_eq({e.tag, "_lo"}, lo, e.lo);
        end
      end
      done_d = req_done && !reset;
    end
  end

  initial begin : guard
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin : main
    int n;
    reset = 1'b1; cancel = 1'b0; req_valid = 1'b0; req_op = '0; req_src1 = '0; req_src2 = '0;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_hi", hi, 0);
    check_eq("rst_lo", lo, 0);
    check_eq("rst_stall", stall, 0);
    check_eq("rst_done", req_done, 0);
    check_eq("rst_tvalid", dif.div_tvalid, 0);
    check_eq("rst_err", err_timeout, 0);

    // signed and unsigned multiply complete in the presenting cycle
    step(); drive(K_MULT, 32'hFFFF_FFFF, 32'h2); push(32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult");
    @(negedge clk);
    check_eq("mult_done", req_done, 1);
    check_eq("mult_stall", stall, 0);
    step(); drive(K_MULTU, 32'hFFFF_FFFF, 32'h2); push(32'h1, 32'hFFFF_FFFE, "multu");
    @(negedge clk);
    check_eq("multu_done", req_done, 1);
    step(); drive(K_MULT | K_MTHI, 32'd3, 32'd4); push(32'd0, 32'd12, "prio_mult");
    @(negedge clk);
    check_eq("prio_mult_done", req_done, 1);
    step(); drive(K_MTHI | K_MTLO, 32'hABCD, 32'd0); push(32'hABCD, m_lo, "prio_mthi");
    @(negedge clk);
    check_eq("prio_mthi_done", req_done, 1);

    // cancel in IDLE: nothing happens
    step(); drive(K_MULT, 32'd5, 32'd5); cancel = 1'b1;
    @(negedge clk);
    check_eq("idle_cancel_done", req_done, 0);
    check_eq("idle_cancel_stall", stall, 0);
    step(); cancel = 1'b0; release_req();
    @(negedge clk);
    check_eq("idle_cancel_hi", hi, m_hi);
    check_eq("idle_cancel_lo", lo, m_lo);

    // signed divide, tready after 3 tvalid cycles, result 5 cycles after handshake
    step(); m_tready_dly = 3; m_dout_dly = 5; unstable = 1'b0;
    drive(K_DIV, 32'hFFFF_FFF9, 32'h2); push(32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
    wait_release(40, n);
    check_eq("div_stall_cycles", n, 9);
    check_eq("div_done", req_done, 1);
    check_eq("div_tv_hold", hs_wait, 3);
    check_eq("div_stable", unstable, 0);
    check_eq("div_dividend", hs_a, 32'hFFFF_FFF9);
    check_eq("div_divisor", hs_b, 32'h2);
    check_eq("div_signed", hs_s, 1);
    step(); release_req();

    // cancel while ISSUE is still waiting for tready
    step(); m_tready_dly = 100; drive(K_DIVU, 32'd100, 32'd7);
    @(negedge clk);
    check_eq("ci_stall", stall, 1);
    step(); cancel = 1'b1;
    @(negedge clk);
    check_eq("ci_tvalid_held", dif.div_tvalid, 1);
    check_eq("ci_unsigned", dif.div_signed, 0);
    step(); cancel = 1'b0; release_req();
    @(negedge clk);
    check_eq("ci_tvalid_drop", dif.div_tvalid, 0);
    check_eq("ci_stall_free", stall, 0);
    check_eq("ci_hi", hi, m_hi);
    check_eq("ci_lo", lo, m_lo);

    // cancel in WAIT, then mtlo waits out the drain
    step(); m_tready_dly = 0; m_dout_dly = 4; drive(K_DIVU, 32'd100, 32'd7);
    step();
    step(); cancel = 1'b1;
    @(negedge clk);
    check_eq("cw_tvalid", dif.div_tvalid, 0);
    check_eq("cw_stall", stall, 1);
    step(); cancel = 1'b0; drive(K_MTLO, 32'h1234, 32'd0); push(m_hi, 32'h1234, "mtlo");
    wait_release(20, n);
    check_eq("cw_drain_stall", n, 3);
    check_eq("cw_mtlo_done", req_done, 1);
    step(); release_req();

    // zero divisor
`ifdef MULDIV_DIV0_SKIP_EN
    step(); drive(K_DIV, 32'd5, 32'd0); push(m_hi, m_lo, "div0");
    @(negedge clk);
    check_eq("div0_done", req_done, 1);
    check_eq("div0_stall", stall, 0);
    check_eq("div0_tvalid", dif.div_tvalid, 0);
    step(); release_req();
    @(negedge clk);
    check_eq("div0_tvalid_next", dif.div_tvalid, 0);
`else
    step(); m_dout_dly = 2; drive(K_DIV, 32'd5, 32'd0); push(32'd5, 32'hFFFF_FFFF, "div0");
    @(negedge clk);
    check_eq("div0_stall", stall, 1);
    step();
    @(negedge clk);
    check_eq("div0_tvalid", dif.div_tvalid, 1);
    check_eq("div0_divisor", dif.div_divisor, 0);
    wait_release(20, n);
    check_eq("div0_wait", n, 1);
    check_eq("div0_done", req_done, 1);
    step(); release_req();
`endif

    // watchdog: result never arrives
    step(); m_tready_dly = 0; m_dout_en = 1'b0; drive(K_DIV, 32'd9, 32'd3);
    wait_release(30, n);
    check_eq("wd_stall_cycles", n, 9);
    check_eq("wd_no_done", req_done, 0);
    check_eq("wd_err_pre", err_timeout, 0);
    step(); release_req();
    @(negedge clk);
    check_eq("wd_err", err_timeout, 1);
    check_eq("wd_stall", stall, 0);
    check_eq("wd_tvalid", dif.div_tvalid, 0);
    step(); drive(K_MTHI, 32'hCAFE, 32'd0); push(32'hCAFE, m_lo, "wd_mthi");
    @(negedge clk);
    check_eq("wd_idle_done", req_done, 1);
    step(); release_req(); m_dout_en = 1'b1;
    repeat (6) step();

    // reset mid-divide; the late result must be ignored
    m_dout_dly = 3; drive(K_DIV, 32'd20, 32'd3);
    step();
    step(); reset = 1'b1; release_req();
    step(); reset = 1'b0; m_hi = '0; m_lo = '0;
    @(negedge clk);
    check_eq("rr_stall", stall, 0);
    check_eq("rr_tvalid", dif.div_tvalid, 0);
    check_eq("rr_hi", hi, 0);
    check_eq("rr_err", err_timeout, 0);
    repeat (5) step();
    @(negedge clk);
    check_eq("rr_late_hi", hi, m_hi);
    check_eq("rr_late_lo", lo, m_lo);

    repeat (3) step();
    check_eq("sb_pending", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
